// File: rtl/seq_word_serializer.sv
// Parallel-in, serial-out word serializer with a one-word holding register so
// back-to-back words stream out with no idle gap between them.
module seq_word_serializer #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ser_bit,
    output logic          ser_vld,
    output logic          ser_last,
    output logic          busy,
    output logic [15:0]   word_cnt
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam int            OUT  = MSB_FIRST ? W - 1 : 0;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_n;
    logic [W-1:0]  sr, sr_n, hr, hr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          hold_full, hold_full_n;
    logic [15:0]   word_cnt_n;
    logic          accept, last_edge;

    always_comb begin
        accept      = in_valid && in_ready;
        last_edge   = (state == SHIFT) && (cnt == LAST);
        state_n     = state;
        sr_n        = sr;
        hr_n        = hr;
        cnt_n       = cnt;
        hold_full_n = hold_full;
        word_cnt_n  = word_cnt + 16'(last_edge);
        if (state == IDLE) begin
            if (accept) begin
                sr_n    = in_data;
                cnt_n   = '0;
                state_n = SHIFT;
            end
        end else if (last_edge) begin
            // Word boundary: refill from HR first, else take a word straight in.
            cnt_n = '0;
            if (hold_full) begin
                sr_n        = hr;
                hold_full_n = 1'b0;
            end else if (accept) begin
                sr_n = in_data;
            end else begin
                state_n = IDLE;
            end
        end else begin
            cnt_n = cnt + 1'b1;
            sr_n  = MSB_FIRST ? {sr[W-2:0], 1'b0} : {1'b0, sr[W-1:1]};
            if (accept) begin
                hr_n        = in_data;
                hold_full_n = 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so each reflects the
    // bit being presented in the cycle after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            cnt       <= '0;
            word_cnt  <= '0;
            ser_bit   <= IDLE_BIT;
            ser_vld   <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            hr        <= hr_n;
            cnt       <= cnt_n;
            hold_full <= hold_full_n;
            word_cnt  <= word_cnt_n;
            ser_vld   <= (state_n == SHIFT);
            ser_bit   <= (state_n == SHIFT) ? sr_n[OUT] : IDLE_BIT;
            ser_last  <= (state_n == SHIFT) && (cnt_n == LAST);
            busy      <= (state_n == SHIFT) || hold_full_n;
            in_ready  <= !hold_full_n;
        end
    end

endmodule
